// File: rtl/sm_trace_buffer.sv
// Execution trace capture for schoolMIPS: circular (cycle, pc, instr) buffer
// with PC-match trigger, post-trigger count, cycle watchdog and registered read port.
//
// state | meaning
// IDLE  | no capture, waiting for arm
// ARMED | capturing every valid sample, watching for the trigger PC
// POST  | trigger seen, capturing the remaining post-trigger samples
// DONE  | capture frozen, buffer readable until the next arm or reset
module sm_trace_buffer #(
    parameter int DEPTH       = 16,
    parameter int CYCLE_WIDTH = 16,
    parameter int TIMEOUT     = 120,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_i,
    input  logic [31:0]            pc_i,
    input  logic [31:0]            instr_i,
    input  logic                   arm_i,
    input  logic                   trig_en_i,
    input  logic [31:0]            trig_pc_i,
    input  logic [AW-1:0]          post_cnt_i,
    input  logic [AW-1:0]          rd_addr_i,
    output logic [31:0]            rd_pc_o,
    output logic [31:0]            rd_instr_o,
    output logic [CYCLE_WIDTH-1:0] rd_cycle_o,
    output logic [AW:0]            count_o,
    output logic [1:0]             state_o,
    output logic                   triggered_o,
    output logic                   timeout_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARMED = 2'b01,
        POST  = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [AW:0]            DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [CYCLE_WIDTH-1:0] CYC_MAX   = '1;
    localparam logic [CYCLE_WIDTH-1:0] TO_VAL    = CYCLE_WIDTH'(TIMEOUT);
    localparam bit                     WD_EN     = (TIMEOUT != 0);

    logic [31:0]            mem_pc    [DEPTH];
    logic [31:0]            mem_instr [DEPTH];
    logic [CYCLE_WIDTH-1:0] mem_cycle [DEPTH];

    state_t                 state_q, state_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW:0]            count_q, count_d;
    logic [CYCLE_WIDTH-1:0] cycle_q, cycle_d;
    logic [AW-1:0]          remain_q, remain_d;
    logic                   triggered_q, triggered_d;
    logic                   timeout_q, timeout_d;
    logic [31:0]            rd_pc_q, rd_pc_d;
    logic [31:0]            rd_instr_q, rd_instr_d;
    logic [CYCLE_WIDTH-1:0] rd_cycle_q, rd_cycle_d;

    logic                   wr_en;
    logic                   wd_hit;
    logic                   trig_hit;
    logic                   rd_hit;
    logic [AW-1:0]          rd_phys;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        cycle_d     = cycle_q;
        remain_d    = remain_q;
        triggered_d = triggered_q;
        timeout_d   = timeout_q;
        wr_en       = 1'b0;
        wd_hit      = WD_EN && (cycle_q == TO_VAL);
        trig_hit    = valid_i && trig_en_i && (pc_i == trig_pc_i);

        if (arm_i) begin
            state_d     = ARMED;
            wr_ptr_d    = '0;
            count_d     = '0;
            cycle_d     = '0;
            remain_d    = post_cnt_i;
            triggered_d = 1'b0;
            timeout_d   = 1'b0;
        end else if (state_q == ARMED || state_q == POST) begin
            // The watchdog cycle freezes the stamp so it reads back as TIMEOUT.
            if (!wd_hit && cycle_q != CYC_MAX) begin
                cycle_d = cycle_q + CYCLE_WIDTH'(1);
            end
            if (valid_i) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + AW'(1);
                if (count_q != DEPTH_CNT) begin
                    count_d = count_q + (AW+1)'(1);
                end
            end
            if (state_q == ARMED) begin
                if (trig_hit) begin
                    triggered_d = 1'b1;
                    state_d     = (remain_q == '0) ? DONE : POST;
                end
            end else if (valid_i) begin
                remain_d = remain_q - AW'(1);
                if (remain_q == AW'(1)) begin
                    state_d = DONE;
                end
            end
            if (wd_hit) begin
                state_d   = DONE;
                timeout_d = 1'b1;
            end
        end
    end

    // Index 0 maps to the oldest valid entry; out-of-range reads return zero.
    always_comb begin
        rd_hit     = ({1'b0, rd_addr_i} < count_q);
        rd_phys    = wr_ptr_q - count_q[AW-1:0] + rd_addr_i;
        rd_pc_d    = '0;
        rd_instr_d = '0;
        rd_cycle_d = '0;
        if (rd_hit) begin
            rd_pc_d    = mem_pc[rd_phys];
            rd_instr_d = mem_instr[rd_phys];
            rd_cycle_d = mem_cycle[rd_phys];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            cycle_q     <= '0;
            remain_q    <= '0;
            triggered_q <= 1'b0;
            timeout_q   <= 1'b0;
            rd_pc_q     <= '0;
            rd_instr_q  <= '0;
            rd_cycle_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            cycle_q     <= cycle_d;
            remain_q    <= remain_d;
            triggered_q <= triggered_d;
            timeout_q   <= timeout_d;
            rd_pc_q     <= rd_pc_d;
            rd_instr_q  <= rd_instr_d;
            rd_cycle_q  <= rd_cycle_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem_pc[wr_ptr_q]    <= pc_i;
            mem_instr[wr_ptr_q] <= instr_i;
            mem_cycle[wr_ptr_q] <= cycle_q;
        end
    end

    assign rd_pc_o     = rd_pc_q;
    assign rd_instr_o  = rd_instr_q;
    assign rd_cycle_o  = rd_cycle_q;
    assign count_o     = count_q;
    assign state_o     = state_q;
    assign triggered_o = triggered_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_sm_trace_buffer.sv
// Directed bench for sm_trace_buffer with DEPTH=8 and TIMEOUT=10.
module tb_sm_trace_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic [31:0] pc_i = '0;
    logic [31:0] instr_i = '0;
    logic        arm_i = 1'b0;
    logic        trig_en_i = 1'b0;
    logic [31:0] trig_pc_i = '0;
    logic [2:0]  post_cnt_i = '0;
    logic [2:0]  rd_addr_i = '0;
    logic [31:0] rd_pc_o;
    logic [31:0] rd_instr_o;
    logic [15:0] rd_cycle_o;
    logic [3:0]  count_o;
    logic [1:0]  state_o;
    logic        triggered_o;
    logic        timeout_o;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] IMASK = 32'hA5A5_0000;

    sm_trace_buffer #(.DEPTH(8), .CYCLE_WIDTH(16), .TIMEOUT(10)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .pc_i(pc_i), .instr_i(instr_i),
        .arm_i(arm_i), .trig_en_i(trig_en_i), .trig_pc_i(trig_pc_i),
        .post_cnt_i(post_cnt_i), .rd_addr_i(rd_addr_i), .rd_pc_o(rd_pc_o),
        .rd_instr_o(rd_instr_o), .rd_cycle_o(rd_cycle_o), .count_o(count_o),
        .state_o(state_o), .triggered_o(triggered_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm(input logic en, input logic [31:0] tpc, input logic [2:0] post);
        arm_i = 1'b1; trig_en_i = en; trig_pc_i = tpc; post_cnt_i = post;
        step();
        arm_i = 1'b0;
    endtask

    task automatic sample(input logic [31:0] pc);
        valid_i = 1'b1; pc_i = pc; instr_i = pc ^ IMASK;
        step();
        valid_i = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a);
        rd_addr_i = a;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        checks++; if (state_o !== 2'b00) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_o); end
        checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count_o); end
        checks++; if (triggered_o !== 1'b0 || timeout_o !== 1'b0) begin errors++; $display("FAIL reset_flags: got trig=%0b to=%0b expected 0 0", triggered_o, timeout_o); end
        checks++; if (rd_pc_o !== 32'd0 || rd_cycle_o !== 16'd0) begin errors++; $display("FAIL reset_rd: got pc=%0h cyc=%0d expected 0 0", rd_pc_o, rd_cycle_o); end
        // IDLE ignores samples
        sample(32'd77);
        checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL idle_nowrite: got %0d expected 0", count_o); end
    endtask

    task automatic test_basic_capture();
        do_arm(1'b0, 32'd0, 3'd0);
        for (int i = 0; i < 5; i++) sample(32'(i));
        checks++; if (count_o !== 4'd5) begin errors++; $display("FAIL basic_count: got %0d expected 5", count_o); end
        checks++; if (state_o !== 2'b01) begin errors++; $display("FAIL basic_state: got %0d expected 1", state_o); end
        rd(3'd0);
        checks++; if (rd_pc_o !== 32'd0 || rd_cycle_o !== 16'd0) begin errors++; $display("FAIL basic_rd0: got pc=%0d cyc=%0d expected 0 0", rd_pc_o, rd_cycle_o); end
        rd(3'd4);
        checks++; if (rd_pc_o !== 32'd4 || rd_cycle_o !== 16'd4) begin errors++; $display("FAIL basic_rd4: got pc=%0d cyc=%0d expected 4 4", rd_pc_o, rd_cycle_o); end
        checks++; if (rd_instr_o !== (32'd4 ^ IMASK)) begin errors++; $display("FAIL basic_rd4_instr: got %0h expected %0h", rd_instr_o, 32'd4 ^ IMASK); end
        rd(3'd5);
        checks++; if (rd_pc_o !== 32'd0 || rd_instr_o !== 32'd0) begin errors++; $display("FAIL basic_rd_oob: got pc=%0h instr=%0h expected 0 0", rd_pc_o, rd_instr_o); end
    endtask

    task automatic test_wrap();
        // 11 back-to-back samples; the last lands exactly on the watchdog cycle
        do_arm(1'b0, 32'd0, 3'd0);
        for (int i = 0; i <= 10; i++) sample(32'(i));
        checks++; if (count_o !== 4'd8) begin errors++; $display("FAIL wrap_count: got %0d expected 8", count_o); end
        rd(3'd0);
        checks++; if (rd_pc_o !== 32'd3) begin errors++; $display("FAIL wrap_rd0: got %0d expected 3", rd_pc_o); end
        rd(3'd7);
        checks++; if (rd_pc_o !== 32'd10 || rd_cycle_o !== 16'd10) begin errors++; $display("FAIL wrap_rd7: got pc=%0d cyc=%0d expected 10 10", rd_pc_o, rd_cycle_o); end
        checks++; if (rd_instr_o !== (32'd10 ^ IMASK)) begin errors++; $display("FAIL wrap_rd7_instr: got %0h expected %0h", rd_instr_o, 32'd10 ^ IMASK); end
        rd(3'd4);
        checks++; if (rd_pc_o !== 32'd7) begin errors++; $display("FAIL wrap_rd4: got %0d expected 7", rd_pc_o); end
        rd(3'd5);
        checks++; if (rd_pc_o !== 32'd8) begin errors++; $display("FAIL wrap_rd5: got %0d expected 8", rd_pc_o); end
        checks++; if (timeout_o !== 1'b1 || state_o !== 2'b11) begin errors++; $display("FAIL wrap_timeout: got to=%0b state=%0d expected 1 3", timeout_o, state_o); end
    endtask

    task automatic test_trigger_post();
        do_arm(1'b1, 32'd6, 3'd2);
        for (int i = 0; i <= 20; i++) sample(32'(i));
        checks++; if (state_o !== 2'b11) begin errors++; $display("FAIL trig_state: got %0d expected 3", state_o); end
        checks++; if (triggered_o !== 1'b1 || timeout_o !== 1'b0) begin errors++; $display("FAIL trig_flags: got trig=%0b to=%0b expected 1 0", triggered_o, timeout_o); end
        checks++; if (count_o !== 4'd8) begin errors++; $display("FAIL trig_count: got %0d expected 8", count_o); end
        rd(3'd7);
        checks++; if (rd_pc_o !== 32'd8 || rd_cycle_o !== 16'd8) begin errors++; $display("FAIL trig_rd7: got pc=%0d cyc=%0d expected 8 8", rd_pc_o, rd_cycle_o); end
        rd(3'd5);
        checks++; if (rd_pc_o !== 32'd6) begin errors++; $display("FAIL trig_rd5: got %0d expected 6", rd_pc_o); end
        rd(3'd0);
        checks++; if (rd_pc_o !== 32'd1) begin errors++; $display("FAIL trig_rd0: got %0d expected 1", rd_pc_o); end
    endtask

    task automatic test_trigger_post0();
        do_arm(1'b1, 32'd3, 3'd0);
        for (int i = 0; i <= 3; i++) sample(32'(i));
        checks++; if (state_o !== 2'b11) begin errors++; $display("FAIL post0_state: got %0d expected 3", state_o); end
        checks++; if (count_o !== 4'd4) begin errors++; $display("FAIL post0_count: got %0d expected 4", count_o); end
        sample(32'd4);
        checks++; if (count_o !== 4'd4) begin errors++; $display("FAIL post0_frozen: got %0d expected 4", count_o); end
        rd(3'd3);
        checks++; if (rd_pc_o !== 32'd3) begin errors++; $display("FAIL post0_last: got %0d expected 3", rd_pc_o); end
    endtask

    task automatic test_timeout();
        do_arm(1'b0, 32'd0, 3'd0);
        for (int k = 0; k < 14; k++) begin
            if (k % 2 == 0) sample(32'(100 + k));
            else step();
        end
        checks++; if (state_o !== 2'b11) begin errors++; $display("FAIL to_state: got %0d expected 3", state_o); end
        checks++; if (timeout_o !== 1'b1 || triggered_o !== 1'b0) begin errors++; $display("FAIL to_flags: got to=%0b trig=%0b expected 1 0", timeout_o, triggered_o); end
        checks++; if (count_o !== 4'd6) begin errors++; $display("FAIL to_count: got %0d expected 6", count_o); end
        rd(3'd5);
        checks++; if (rd_pc_o !== 32'd110 || rd_cycle_o !== 16'd10) begin errors++; $display("FAIL to_last: got pc=%0d cyc=%0d expected 110 10", rd_pc_o, rd_cycle_o); end
        rd(3'd2);
        checks++; if (rd_pc_o !== 32'd104 || rd_cycle_o !== 16'd4) begin errors++; $display("FAIL to_mid: got pc=%0d cyc=%0d expected 104 4", rd_pc_o, rd_cycle_o); end
    endtask

    task automatic test_arm_vs_trigger();
        do_arm(1'b1, 32'd50, 3'd1);
        sample(32'd48);
        sample(32'd49);
        arm_i = 1'b1; valid_i = 1'b1; pc_i = 32'd50; instr_i = 32'd50 ^ IMASK;
        step();
        arm_i = 1'b0; valid_i = 1'b0;
        checks++; if (state_o !== 2'b01) begin errors++; $display("FAIL armtrig_state: got %0d expected 1", state_o); end
        checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL armtrig_count: got %0d expected 0", count_o); end
        checks++; if (triggered_o !== 1'b0) begin errors++; $display("FAIL armtrig_trig: got %0b expected 0", triggered_o); end
    endtask

    task automatic test_reset_in_post();
        rd_addr_i = 3'd1;
        do_arm(1'b1, 32'd2, 3'd5);
        sample(32'd1000);
        sample(32'd1001);
        sample(32'd2);
        checks++; if (state_o !== 2'b10 || triggered_o !== 1'b1) begin errors++; $display("FAIL post_entry: got state=%0d trig=%0b expected 2 1", state_o, triggered_o); end
        checks++; if (rd_pc_o !== 32'd1001) begin errors++; $display("FAIL post_rd1: got %0d expected 1001", rd_pc_o); end
        rst = 1'b1; arm_i = 1'b1; valid_i = 1'b1; pc_i = 32'd9;
        step();
        rst = 1'b0; arm_i = 1'b0; valid_i = 1'b0;
        checks++; if (state_o !== 2'b00 || count_o !== 4'd0) begin errors++; $display("FAIL rst_post_state: got state=%0d count=%0d expected 0 0", state_o, count_o); end
        checks++; if (triggered_o !== 1'b0 || timeout_o !== 1'b0) begin errors++; $display("FAIL rst_post_flags: got trig=%0b to=%0b expected 0 0", triggered_o, timeout_o); end
        checks++; if (rd_pc_o !== 32'd0 || rd_instr_o !== 32'd0 || rd_cycle_o !== 16'd0) begin errors++; $display("FAIL rst_post_rd: got pc=%0h instr=%0h cyc=%0d expected 0 0 0", rd_pc_o, rd_instr_o, rd_cycle_o); end
    endtask

    initial begin
        test_reset();
        test_basic_capture();
        test_wrap();
        test_trigger_post();
        test_trigger_post0();
        test_timeout();
        test_arm_vs_trigger();
        test_reset_in_post();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
